// File: rtl/uart_pkg.sv
// Shared UART transmitter types: FSM state encoding, parity configuration
// codes and the parity helper used when a word is captured.
package uart_pkg;

    // Widest payload the transmitter supports; the parity helper is sized to it.
    localparam int MAX_DATA_WIDTH = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        GUARD  = 3'd5
    } uart_tx_state_t;

    // Bit 1 enables parity, bit 0 selects odd (1) or even (0).
    typedef logic [1:0] uart_parity_t;

    localparam uart_parity_t PAR_NONE = 2'b00;
    localparam uart_parity_t PAR_EVEN = 2'b10;
    localparam uart_parity_t PAR_ODD  = 2'b11;

    // Zero-extended payloads do not change the XOR, so narrower words are fine.
    function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                         input logic odd);
        return odd ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO holding captured transmit words together with
// their per-word line configuration. Reset empties it immediately.
module uart_tx_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             doPush;
    logic             doPop;

    // A full FIFO refuses the push even when a pop happens on the same edge.
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rdPtr_q];

    // Storage array needs no reset; the occupancy count decides what is valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, LSB-first payload, optional
// parity, one or two stop bits and idle guard bits, each bit held for
// OVERSAMPLE clocks. Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry
// FIFO in front of the serialiser; otherwise a single capture register
// is used and a new word is only taken while the line is idle.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int GUARD_BITS = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [1:0]            parity_config,
    input  logic                  stop_two,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int IW = $clog2(DATA_WIDTH);
    localparam int EW = DATA_WIDTH + 3;

    uart_tx_state_t        state_q;
    logic [CW-1:0]         bitCnt_q;
    logic [IW-1:0]         idx_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  parEn_q;
    logic                  parBit_q;
    logic                  stopTwo_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  done_q;

    logic [EW-1:0]         entryIn;
    logic [EW-1:0]         headEntry;
    logic                  headValid;
    logic [DATA_WIDTH-1:0] headData;
    logic [1:0]            headPar;
    logic                  headStop;
    logic                  pop;
    logic                  bitLast;
    logic                  stopLast;
    logic                  frameEnd;

    // Word and line configuration travel together so a frame never mixes settings.
    assign entryIn  = {stop_two, parity_config, data_in};
    assign headData = headEntry[DATA_WIDTH-1:0];
    assign headPar  = headEntry[DATA_WIDTH+1:DATA_WIDTH];
    assign headStop = headEntry[DATA_WIDTH+2];
    assign pop      = (state_q == IDLE) && headValid;

    assign bitLast  = (bitCnt_q == CW'(OVERSAMPLE - 1));
    assign stopLast = !(stopTwo_q && (idx_q == '0));
    assign frameEnd = bitLast &&
                      (((state_q == STOP) && (GUARD_BITS == 0) && stopLast) ||
                       ((state_q == GUARD) && (idx_q == IW'(GUARD_BITS - 1))));

`ifdef UART_TX_FIFO_EN
    logic fifoFull;
    logic fifoEmpty;

    uart_tx_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (valid_in),
        .wdata_i (entryIn),
        .pop_i   (pop),
        .rdata_o (headEntry),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign headValid = !fifoEmpty;
    assign ready_out = !fifoFull;
`else
    logic [EW-1:0] cap_q;
    logic          capValid_q;
    logic          ready_q;

    // Single holding register: filled on a transfer, emptied when the frame starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q      <= '0;
            capValid_q <= 1'b0;
        end else if (valid_in && ready_q) begin
            cap_q      <= entryIn;
            capValid_q <= 1'b1;
        end else if (pop) begin
            capValid_q <= 1'b0;
        end
    end

    // Ready drops on the transfer and returns on the edge the line goes idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b1;
        end else if (valid_in && ready_q) begin
            ready_q <= 1'b0;
        end else if (frameEnd) begin
            ready_q <= 1'b1;
        end
    end

    assign headEntry = cap_q;
    assign headValid = capValid_q;
    assign ready_out = ready_q;
`endif

    // Frame sequencer: walks the bit slots and drives the registered line outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bitCnt_q  <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            parEn_q   <= 1'b0;
            parBit_q  <= 1'b0;
            stopTwo_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if ((state_q == IDLE) || bitLast) begin
                bitCnt_q <= '0;
            end else begin
                bitCnt_q <= bitCnt_q + CW'(1);
            end

            if (frameEnd) begin
                state_q <= IDLE;
                tx_q    <= 1'b1;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                idx_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (headValid) begin
                            state_q   <= START;
                            tx_q      <= 1'b0;
                            busy_q    <= 1'b1;
                            idx_q     <= '0;
                            shift_q   <= headData;
                            parEn_q   <= headPar[1];
                            parBit_q  <= calc_parity(MAX_DATA_WIDTH'(headData), headPar[0]);
                            stopTwo_q <= headStop;
                        end
                    end
                    START: begin
                        if (bitLast) begin
                            state_q <= DATA;
                            tx_q    <= shift_q[0];
                            idx_q   <= '0;
                        end
                    end
                    DATA: begin
                        if (bitLast) begin
                            if (idx_q == IW'(DATA_WIDTH - 1)) begin
                                idx_q <= '0;
                                if (parEn_q) begin
                                    state_q <= PARITY;
                                    tx_q    <= parBit_q;
                                end else begin
                                    state_q <= STOP;
                                    tx_q    <= 1'b1;
                                end
                            end else begin
                                idx_q   <= idx_q + IW'(1);
                                shift_q <= shift_q >> 1;
                                tx_q    <= shift_q[1];
                            end
                        end
                    end
                    PARITY: begin
                        if (bitLast) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                            idx_q   <= '0;
                        end
                    end
                    STOP: begin
                        if (bitLast) begin
                            if (!stopLast) begin
                                idx_q <= IW'(1);
                            end else begin
                                state_q <= GUARD;
                                tx_q    <= 1'b1;
                                idx_q   <= '0;
                            end
                        end
                    end
                    GUARD: begin
                        if (bitLast) begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param. Expected frames are queued when a
// word is handed over and compared bit slot by bit slot as the line plays
// them out. Define UART_TX_FIFO_EN to exercise the FIFO build.
module tb_uart_tx_param;
    import uart_pkg::*;

    localparam int DW         = 8;
    localparam int OS         = 16;
    localparam int GB         = 1;
    localparam int FD         = 4;
    localparam int WAIT_LIMIT = 3000;

`ifdef UART_TX_FIFO_EN
    localparam int  GAP_EXP           = 1;
    localparam bit  READY_LOW_IN_FRAME = 1'b0;
`else
    // The frame_done cycle is followed by the transfer cycle, then the start bit.
    localparam int  GAP_EXP           = 2;
    localparam bit  READY_LOW_IN_FRAME = 1'b1;
`endif

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        logic [7:0]  data;
    } frame_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          valid_in = 1'b0;
    logic [1:0]    parity_config = PAR_NONE;
    logic          stop_two = 1'b0;
    logic          ready_out;
    logic          tx;
    logic          busy;
    logic          frame_done;

    frame_t      expQ[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    frame_t      cur;
    logic        monActive = 1'b0;
    logic        endCheck = 1'b0;
    logic        bitBad = 1'b0;
    logic [3:0]  badVals;
    int          monBit = 0;
    int          monCyc = 0;
    logic [15:0] lastBits = '1;
    int          framesDone = 0;
    int          doneCount = 0;
    int          startCyc = 0;
    int          lastLen = 0;
    int          lastDoneCyc = -1000;
    int          lastGap = 0;
    int          gapOkCount = 0;

    uart_tx_param #(
        .DATA_WIDTH (DW),
        .OVERSAMPLE (OS),
        .GUARD_BITS (GB),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .parity_config (parity_config),
        .stop_two      (stop_two),
        .tx            (tx),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    // 10 ns clock period
    always #5 clk = ~clk;

    // Cycle counter used for frame length and inter-frame gap measurements
    always @(posedge clk) cyc++;

    // Reference frame: start, LSB-first data, optional parity, stop bits, guard bits
    function automatic frame_t make_frame(input logic [7:0] d, input logic [1:0] p, input logic s);
        frame_t f;
        int n;
        f.bits = '1;
        f.data = d;
        n = 0;
        f.bits[n] = 1'b0;
        n++;
        for (int i = 0; i < DW; i++) begin
            f.bits[n] = d[i];
            n++;
        end
        if (p[1]) begin
            f.bits[n] = p[0] ? ~(^d) : (^d);
            n++;
        end
        n += (s ? 2 : 1) + GB;
        f.nbits = n;
        return f;
    endfunction

    // Line monitor: pops the expected frame at each start bit and checks every slot
    always @(negedge clk) begin
        if (rst) begin
            monActive = 1'b0;
            endCheck  = 1'b0;
        end else begin
            if (frame_done === 1'b1) doneCount++;
            if (endCheck) begin
                endCheck = 1'b0;
                checks++;
                if (frame_done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL frame_end data=%h got done=%b busy=%b tx=%b required 1 0 1",
                             cur.data, frame_done, busy, tx);
                end
                lastLen     = cyc - startCyc;
                lastDoneCyc = cyc;
                framesDone++;
            end else if (!monActive && tx === 1'b0) begin
                lastGap  = cyc - lastDoneCyc;
                if (lastGap == GAP_EXP) gapOkCount++;
                startCyc = cyc;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_start at cycle %0d got start bit required idle line", cyc);
                    cur = make_frame(8'h00, PAR_NONE, 1'b0);
                end else begin
                    cur = expQ.pop_front();
                end
                monActive = 1'b1;
                monBit    = 0;
                monCyc    = 0;
                bitBad    = 1'b0;
                lastBits  = '1;
            end
            if (monActive) begin
                if (!bitBad && (tx !== cur.bits[monBit] || busy !== 1'b1 || frame_done !== 1'b0 ||
                                (READY_LOW_IN_FRAME && ready_out !== 1'b0))) begin
                    bitBad  = 1'b1;
                    badVals = {tx, busy, frame_done, ready_out};
                end
                monCyc++;
                if (monCyc == OS) begin
                    checks++;
                    if (bitBad) begin
                        errors++;
                        $display("[TB] FAIL frame_bit data=%h slot=%0d got tx/busy/done/ready=%b required tx=%b busy=1 done=0",
                                 cur.data, monBit, badVals, cur.bits[monBit]);
                    end
                    lastBits[monBit] = tx;
                    bitBad = 1'b0;
                    monCyc = 0;
                    monBit++;
                    if (monBit == cur.nbits) begin
                        monActive = 1'b0;
                        endCheck  = 1'b1;
                    end
                end
            end
        end
    end

    // Hand one word over on the valid/ready handshake and queue its expected frame
    task automatic applyStimulus(input logic [7:0] d, input logic [1:0] p, input logic s, input bit hold);
        int n;
        data_in       = d;
        parity_config = p;
        stop_two      = s;
        valid_in      = 1'b1;
        n = 0;
        while (ready_out !== 1'b1 && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (ready_out !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout data=%h got ready=%b required 1", d, ready_out);
            valid_in = 1'b0;
            return;
        end
        @(posedge clk);
        expQ.push_back(make_frame(d, p, s));
        #1;
        if (!hold) valid_in = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (framesDone < target && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (framesDone < target) begin
            errors++;
            $display("[TB] FAIL frame_timeout got %0d frames required %0d", framesDone, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1)         begin errors++; $display("[TB] FAIL reset_tx got %b required 1", tx); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL reset_busy got %b required 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b required 0", frame_done); end
        checks++; if (ready_out !== 1'b1)  begin errors++; $display("[TB] FAIL reset_ready got %b required 1", ready_out); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1)         begin errors++; $display("[TB] FAIL post_reset_tx got %b required 1", tx); end
        checks++; if (ready_out !== 1'b1)  begin errors++; $display("[TB] FAIL post_reset_ready got %b required 1", ready_out); end
    endtask

    task automatic test_basic();
        int base;
        int d0;
        base = framesDone;
        d0   = doneCount;
        applyStimulus(8'hA5, PAR_NONE, 1'b0, 1'b0);
        wait_frames(base + 1);
        checks++; if (lastLen != 176)        begin errors++; $display("[TB] FAIL basic_length got %0d required 176", lastLen); end
        checks++; if (doneCount - d0 != 1)   begin errors++; $display("[TB] FAIL basic_done_pulses got %0d required 1", doneCount - d0); end
        checks++; if (ready_out !== 1'b1)    begin errors++; $display("[TB] FAIL basic_ready_after got %b required 1", ready_out); end
    endtask

    task automatic test_parity();
        logic [1:0] parTab [4] = '{PAR_EVEN, PAR_ODD, PAR_ODD, 2'b01};
        logic       stopTab[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int         lenTab [4] = '{192, 192, 208, 176};
        logic       bitTab [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        int base;
        for (int i = 0; i < 4; i++) begin
            base = framesDone;
            applyStimulus(8'hA5, parTab[i], stopTab[i], 1'b0);
            wait_frames(base + 1);
            checks++;
            if (lastLen != lenTab[i]) begin
                errors++;
                $display("[TB] FAIL parity_length cfg=%b stop2=%b got %0d required %0d", parTab[i], stopTab[i], lastLen, lenTab[i]);
            end
            checks++;
            if (lastBits[9] !== bitTab[i]) begin
                errors++;
                $display("[TB] FAIL parity_slot9 cfg=%b got %b required %b", parTab[i], lastBits[9], bitTab[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = framesDone;
        applyStimulus(8'h00, PAR_NONE, 1'b0, 1'b1);
        applyStimulus(8'hFF, PAR_NONE, 1'b0, 1'b0);
        wait_frames(base + 2);
        checks++; if (lastGap != GAP_EXP) begin errors++; $display("[TB] FAIL b2b_gap got %0d required %0d", lastGap, GAP_EXP); end
        checks++; if (lastLen != 176)     begin errors++; $display("[TB] FAIL b2b_length got %0d required 176", lastLen); end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        int d0;
        int n;
        base = framesDone;
        d0   = doneCount;
        applyStimulus(8'hC3, PAR_EVEN, 1'b1, 1'b0);
        n = 0;
        while (!(monActive && (cyc - startCyc) >= 50) && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (tx !== 1'b1)         begin errors++; $display("[TB] FAIL midreset_tx got %b required 1", tx); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL midreset_busy got %b required 0", busy); end
        checks++; if (ready_out !== 1'b1)  begin errors++; $display("[TB] FAIL midreset_ready got %b required 1", ready_out); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done got %b required 0", frame_done); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4 * OS) @(negedge clk);
        checks++; if (doneCount != d0)     begin errors++; $display("[TB] FAIL midreset_no_done got %0d pulses required 0", doneCount - d0); end
        checks++; if (framesDone != base)  begin errors++; $display("[TB] FAIL midreset_no_frame got %0d frames required %0d", framesDone, base); end
        applyStimulus(8'h3C, PAR_ODD, 1'b0, 1'b0);
        wait_frames(base + 1);
        checks++; if (lastLen != 192)      begin errors++; $display("[TB] FAIL midreset_clean_length got %0d required 192", lastLen); end
    endtask

    task automatic test_midframe_change();
        int base;
        base = framesDone;
        applyStimulus(8'h5A, PAR_EVEN, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        data_in       = 8'hFF;
        parity_config = PAR_ODD;
        stop_two      = 1'b1;
        wait_frames(base + 1);
        checks++; if (lastLen != 192)      begin errors++; $display("[TB] FAIL change_length got %0d required 192", lastLen); end
        checks++; if (lastBits[9] !== 1'b0) begin errors++; $display("[TB] FAIL change_parity got %b required 0", lastBits[9]); end
        parity_config = PAR_NONE;
        stop_two      = 1'b0;
    endtask

`ifdef UART_TX_FIFO_EN
    task automatic test_fifo_burst();
        logic [7:0] words[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        int base;
        int g0;
        base = framesDone;
        g0   = gapOkCount;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(words[i], PAR_NONE, 1'b0, i < 4);
        end
        checks++; if (ready_out !== 1'b0)  begin errors++; $display("[TB] FAIL fifo_full_ready got %b required 0", ready_out); end
        wait_frames(base + 5);
        checks++; if (gapOkCount - g0 < 4) begin errors++; $display("[TB] FAIL fifo_gaps got %0d one-cycle gaps required 4", gapOkCount - g0); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_midframe_change();
`ifdef UART_TX_FIFO_EN
        test_fifo_burst();
`endif
        repeat (4) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL leftover_frames got %0d required 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
